usbh_report_arbiter: RTL

Merges HID reports from up to C_ports independent `usbh_host_hid` instances (US2/US3/US4) into one report stream for the display/decoder path. Each port gets a capture buffer with pending and overrun flags. A round-robin scheduler forwards one buffered report at a time over a valid/ready handshake, tagged with its source port. Per-port inactivity timers flag disconnected devices. The block sits between the HID host instances (clk_usb domain) and the consumer of `S_report`.

---
 rtl/usbh_report_pkg.sv | 14 +
 rtl/usbh_report_port.sv | 81 ++++++++
 rtl/usbh_report_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/usbh_report_pkg.sv
// Shared definitions for the HID report arbiter: scheduler states and default report size.
// Latency: none (package only).
// Backpressure: not applicable.
package usbh_report_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    localparam int C_REPORT_LENGTH_DEFAULT = 20;
    localparam int C_PORT_IDX_W            = 2;

endpackage

// File: rtl/usbh_report_port.sv
// One HID port: capture buffer, pending/overrun flags and inactivity timer with connected flag.
// Latency: in_valid -> pend/connected one cycle later.
// Backpressure: none; a new report overwrites an unforwarded one and flags overrun.
module usbh_report_port
    import usbh_report_pkg::*;
#(
    parameter int C_report_length = C_REPORT_LENGTH_DEFAULT,
    parameter int C_timeout_bits  = 22
) (
    input  logic                         clk,
    input  logic                         resn,
    input  logic                         i_valid,
    input  logic [C_report_length*8-1:0] i_report,
    input  logic                         i_grant,
    input  logic                         i_clear_overrun,
    output logic [C_report_length*8-1:0] o_buf,
    output logic                         o_pend,
    output logic                         o_overrun,
    output logic                         o_connected
);

    localparam logic [C_timeout_bits-1:0] TMR_MAX = '1;

    logic [C_report_length*8-1:0] r_buf;
    logic                         r_pend;
    logic                         r_overrun;
    logic [C_timeout_bits-1:0]    r_tmr;
    logic                         r_connected;
    logic                         w_ovr_set;

    // Overwriting a report that is still waiting (and not leaving this cycle) loses it.
    assign w_ovr_set = i_valid && r_pend && !i_grant;

    // Capture buffer and pending flag; a new strobe keeps pend set even when granted.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_buf  <= '0;
            r_pend <= 1'b0;
        end else if (i_valid) begin
            r_buf  <= i_report;
            r_pend <= 1'b1;
        end else if (i_grant) begin
            r_pend <= 1'b0;
        end
    end

    // Sticky overrun; setting wins over a same-cycle clear.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (i_clear_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    // Saturating inactivity timer; connected drops on the edge the timer reaches all-ones.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_tmr       <= '0;
            r_connected <= 1'b0;
        end else if (i_valid) begin
            r_tmr       <= '0;
            r_connected <= 1'b1;
        end else begin
            if (r_tmr != TMR_MAX) begin
                r_tmr <= r_tmr + 1'b1;
            end
            if (r_tmr == TMR_MAX - 1'b1) begin
                r_connected <= 1'b0;
            end
        end
    end

    assign o_buf       = r_buf;
    assign o_pend      = r_pend;
    assign o_overrun   = r_overrun;
    assign o_connected = r_connected;

endmodule

// File: rtl/usbh_report_arbiter.sv
// Merges per-port HID reports into one tagged stream using round-robin scheduling.
// Latency: in_valid at t -> out_valid at t+2 at best; one report per two cycles maximum.
// Backpressure: out_* held while out_valid & !out_ready; ports keep buffering (overrun on loss).
module usbh_report_arbiter
    import usbh_report_pkg::*;
#(
    parameter int C_ports         = 3,
    parameter int C_report_length = C_REPORT_LENGTH_DEFAULT,
    parameter int C_timeout_bits  = 22
) (
    input  logic                                 clk,
    input  logic                                 resn,
    input  logic [C_ports*C_report_length*8-1:0] in_report,
    input  logic [C_ports-1:0]                   in_valid,
    output logic [C_report_length*8-1:0]         out_report,
    output logic [C_PORT_IDX_W-1:0]              out_port,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [C_ports-1:0]                   overrun,
    input  logic [C_ports-1:0]                   clear_overrun,
    output logic [C_ports-1:0]                   connected
);

    localparam int W = C_report_length * 8;

    logic [W-1:0]              w_buf [C_ports];
    logic [C_ports-1:0]        w_pend;
    logic [C_ports-1:0]        w_grant;
    logic [3:0]                w_pend4;
    logic                      w_found;
    logic [C_PORT_IDX_W-1:0]   w_gidx;
    logic [C_PORT_IDX_W-1:0]   w_idx;
    logic [C_PORT_IDX_W-1:0]   w_ptr_nxt;
    logic [W-1:0]              w_sel;
    logic                      w_take;
    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [C_PORT_IDX_W-1:0]   r_ptr;
    logic [W-1:0]              r_report;
    logic [C_PORT_IDX_W-1:0]   r_port;

    for (genvar k = 0; k < C_ports; k++) begin : g_port
        usbh_report_port #(
            .C_report_length (C_report_length),
            .C_timeout_bits  (C_timeout_bits)
        ) u_port (
            .clk             (clk),
            .resn            (resn),
            .i_valid         (in_valid[k]),
            .i_report        (in_report[k*W +: W]),
            .i_grant         (w_grant[k]),
            .i_clear_overrun (clear_overrun[k]),
            .o_buf           (w_buf[k]),
            .o_pend          (w_pend[k]),
            .o_overrun       (overrun[k]),
            .o_connected     (connected[k])
        );
    end

    // Absent ports read as never pending.
    assign w_pend4 = 4'(w_pend);

    // First pending port at or after the pointer, wrapping modulo C_ports.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int i = 0; i < C_ports; i++) begin
            w_idx = C_PORT_IDX_W'((int'(r_ptr) + i) % C_ports);
            if (!w_found && w_pend4[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (w_gidx == C_PORT_IDX_W'(C_ports - 1)) ? '0 : w_gidx + 1'b1;

    // Select the granted port's buffer.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < C_ports; k++) begin
            if (w_gidx == C_PORT_IDX_W'(k)) begin
                w_sel = w_buf[k];
            end
        end
    end

    // Scheduler next state and grant; grants only from IDLE so each report gets its own handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = '0;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_take      = 1'b1;
                    w_grant     = C_ports'(4'b0001 << w_gidx);
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output register and round-robin pointer, loaded only on a grant so later buffer writes cannot disturb it.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_report <= '0;
            r_port   <= '0;
            r_ptr    <= '0;
        end else if (w_take) begin
            r_report <= w_sel;
            r_port   <= w_gidx;
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign out_report = r_report;
    assign out_port   = r_port;
    assign out_valid  = (r_state == ST_PRESENT);

endmodule
